alu_seq: RTL

- Parametrised, handshaked successor to the execute-stage combinational ALU.
- Adds the RV32M multiply/divide group, computed iteratively, and full branch-compare coverage. Width is parametrised.
- Sits in EX between the ID/EX register and EX/MEM register.
- Stalls the pipeline through valid/ready while a multi-cycle op runs.
- Result, zero flag and branch flag are all registered.

---
 rtl/alu_seq.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with iterative RV32M multiply/divide.
// Single-cycle ops land in DONE after one edge; MUL/DIV ops take XLEN+1 edges.
// Optional macro ALU_SEQ_DIV_EN: when defined, the restoring divider and DIV
// state exist; when undefined, divide/remainder ops return all ones in one cycle.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [4:0]      ALUCtrl_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] data_o,
  output logic            Zero_o,
  output logic            branch_flag_o,
  output logic            busy_o
);

  localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB  = 5'b00001, OP_SLL  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011, OP_SRL  = 5'b00100, OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_AND  = 5'b00111, OP_SLT  = 5'b01000;
  localparam logic [4:0] OP_SLTU = 5'b01001, OP_BEQ  = 5'b01010, OP_BNE  = 5'b01011;
  localparam logic [4:0] OP_BLT  = 5'b01100, OP_BGE  = 5'b01101, OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111, OP_MUL  = 5'b10000, OP_MULH = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
`ifndef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b10100, OP_DIVU = 5'b10101, OP_REM  = 5'b10110;
  localparam logic [4:0] OP_REMU = 5'b10111;
`endif

`ifdef ALU_SEQ_DIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd3} state_t;
`endif

  state_t                state_q, state_d;
  logic [SHW-1:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic                  zero_q, zero_d, br_q, br_d, valid_q, valid_d, busy_q, busy_d;
  logic [2*XLEN-1:0]     acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic                  bsgn_q, bsgn_d, hi_q, hi_d;

  logic                  ready_s, accept_s, last_s, alu_br_s, is_mul_s, asgn_s;
  logic [XLEN-1:0]       alu_res_s;
  logic [SHW-1:0]        shamt_s;
  logic [2*XLEN-1:0]     acc_nx_s;

`ifdef ALU_SEQ_DIV_EN
  logic [XLEN-1:0]       quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
  logic                  qneg_q, qneg_d, rneg_q, rneg_d, wrem_q, wrem_d;
  logic                  is_div_s, dsgn_s, aneg_s, bneg_s;
  logic [XLEN:0]         part_s, diff_s;
  logic [XLEN-1:0]       quo_nx_s, rem_nx_s, div_res_s;
`endif

  assign ready_s       = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
  assign accept_s      = valid_i && ready_s && !flush_i;
  assign last_s        = (cnt_q == SHW'(XLEN - 1));
  assign shamt_s       = data2_i[SHW-1:0];
  assign is_mul_s      = (ALUCtrl_i[4:2] == 3'b100);
  assign asgn_s        = (ALUCtrl_i == OP_MULH) || (ALUCtrl_i == OP_MULHSU);
  assign ready_o       = ready_s;
  assign valid_o       = valid_q;
  assign data_o        = data_q;
  assign Zero_o        = zero_q;
  assign branch_flag_o = br_q;
  assign busy_o        = busy_q;

  // Single-cycle result and branch compare from the live operands.
  always_comb begin
    alu_res_s = data1_i;
    alu_br_s  = 1'b0;
    case (ALUCtrl_i)
      OP_ADD:  alu_res_s = data1_i + data2_i;
      OP_SUB:  alu_res_s = data1_i - data2_i;
      OP_SLL:  alu_res_s = data1_i << shamt_s;
      OP_XOR:  alu_res_s = data1_i ^ data2_i;
      OP_SRL:  alu_res_s = data1_i >> shamt_s;
      OP_SRA:  alu_res_s = $unsigned($signed(data1_i) >>> shamt_s);
      OP_OR:   alu_res_s = data1_i | data2_i;
      OP_AND:  alu_res_s = data1_i & data2_i;
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (data1_i < data2_i)};
      OP_BEQ:  begin alu_res_s = data1_i - data2_i; alu_br_s = (data1_i == data2_i); end
      OP_BNE:  begin alu_res_s = data1_i - data2_i; alu_br_s = (data1_i != data2_i); end
      OP_BLT:  begin alu_res_s = data1_i - data2_i; alu_br_s = ($signed(data1_i) < $signed(data2_i)); end
      OP_BGE:  begin alu_res_s = data1_i - data2_i; alu_br_s = ($signed(data1_i) >= $signed(data2_i)); end
      OP_BLTU: begin alu_res_s = data1_i - data2_i; alu_br_s = (data1_i < data2_i); end
      OP_BGEU: begin alu_res_s = data1_i - data2_i; alu_br_s = (data1_i >= data2_i); end
`ifndef ALU_SEQ_DIV_EN
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res_s = {XLEN{1'b1}};
`endif
      default: alu_res_s = data1_i;
    endcase
  end

  // One shift-add step; the top multiplier bit carries negative weight for MULH.
  always_comb begin
    acc_nx_s = acc_q;
    if (mplier_q[0]) begin
      if (bsgn_q && last_s) begin
        acc_nx_s = acc_q - mcand_q;
      end else begin
        acc_nx_s = acc_q + mcand_q;
      end
    end else begin
      acc_nx_s = acc_q;
    end
  end

`ifdef ALU_SEQ_DIV_EN
  assign is_div_s = (ALUCtrl_i[4:2] == 3'b101);
  assign dsgn_s   = !ALUCtrl_i[0];
  assign aneg_s   = dsgn_s && data1_i[XLEN-1];
  assign bneg_s   = dsgn_s && data2_i[XLEN-1];

  // One restoring-divide step on magnitudes plus the final sign fix-up.
  always_comb begin
    part_s = {rem_q, quo_q[XLEN-1]};
    diff_s = part_s - {1'b0, dsr_q};
    if (!diff_s[XLEN]) begin
      rem_nx_s = diff_s[XLEN-1:0];
      quo_nx_s = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nx_s = part_s[XLEN-1:0];
      quo_nx_s = {quo_q[XLEN-2:0], 1'b0};
    end
    if (wrem_q) begin
      div_res_s = rneg_q ? (-rem_nx_s) : rem_nx_s;
    end else begin
      div_res_s = qneg_q ? (-quo_nx_s) : quo_nx_s;
    end
  end
`endif

  // Next-state, datapath and output-register logic; flush beats accept.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    br_d     = br_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    bsgn_d   = bsgn_q;
    hi_d     = hi_q;
`ifdef ALU_SEQ_DIV_EN
    quo_d    = quo_q;
    rem_d    = rem_q;
    dsr_d    = dsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    wrem_d   = wrem_q;
`endif
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = {SHW{1'b0}};
    end else if (accept_s) begin
      cnt_d = {SHW{1'b0}};
      if (is_mul_s) begin
        state_d  = S_MUL;
        acc_d    = {(2*XLEN){1'b0}};
        mcand_d  = asgn_s ? {{XLEN{data1_i[XLEN-1]}}, data1_i} : {{XLEN{1'b0}}, data1_i};
        mplier_d = data2_i;
        bsgn_d   = (ALUCtrl_i == OP_MULH);
        hi_d     = (ALUCtrl_i != OP_MUL);
`ifdef ALU_SEQ_DIV_EN
      end else if (is_div_s) begin
        state_d = S_DIV;
        quo_d   = aneg_s ? (-data1_i) : data1_i;
        dsr_d   = bneg_s ? (-data2_i) : data2_i;
        rem_d   = {XLEN{1'b0}};
        qneg_d  = (aneg_s ^ bneg_s) && (data2_i != {XLEN{1'b0}});
        rneg_d  = aneg_s;
        wrem_d  = ALUCtrl_i[1];
`endif
      end else begin
        state_d = S_DONE;
        data_d  = alu_res_s;
        br_d    = alu_br_s;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          acc_d    = acc_nx_s;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (last_s) begin
            state_d = S_DONE;
            data_d  = hi_q ? acc_nx_s[2*XLEN-1:XLEN] : acc_nx_s[XLEN-1:0];
            br_d    = 1'b0;
          end else begin
            state_d = S_MUL;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          quo_d = quo_nx_s;
          rem_d = rem_nx_s;
          cnt_d = cnt_q + SHW'(1);
          if (last_s) begin
            state_d = S_DONE;
            data_d  = div_res_s;
            br_d    = 1'b0;
          end else begin
            state_d = S_DIV;
          end
        end
`endif
        S_DONE: begin
          if (ready_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    zero_d  = (data_d == {XLEN{1'b0}});
    valid_d = (state_d == S_DONE);
`ifdef ALU_SEQ_DIV_EN
    busy_d  = (state_d == S_MUL) || (state_d == S_DIV);
`else
    busy_d  = (state_d == S_MUL);
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {SHW{1'b0}};
      data_q   <= {XLEN{1'b0}};
      zero_q   <= 1'b1;
      br_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      acc_q    <= {(2*XLEN){1'b0}};
      mcand_q  <= {(2*XLEN){1'b0}};
      mplier_q <= {XLEN{1'b0}};
      bsgn_q   <= 1'b0;
      hi_q     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      quo_q    <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      dsr_q    <= {XLEN{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      wrem_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
      br_q     <= br_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      bsgn_q   <= bsgn_d;
      hi_q     <= hi_d;
`ifdef ALU_SEQ_DIV_EN
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      wrem_q   <= wrem_d;
`endif
    end
  end

endmodule
